// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong scanline buffer between a pixel producer
// and the VGA colour pins; one bank fills while the other is displayed.
module vga_line_buffer #(
  parameter int H_ACTIVE    = 417,
  parameter int LINE_LENGTH = 508,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 526,
  parameter int COLOR_W     = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [15:0]        pixel_x,
  input  logic [15:0]        line_y,
  input  logic               wr_valid,
  input  logic [COLOR_W-1:0] wr_rgb,
  output logic               wr_ready,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               underrun,
  output logic [7:0]         underrun_count
);

  localparam int IDX_W  = $clog2(H_ACTIVE + 1);
  localparam int DEPTH  = 2 * H_ACTIVE;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_e;

  fill_e              state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bank_q, bank_d;
  logic               valid_q, valid_d;
  logic               und_q, und_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rd_en_q;
  logic [COLOR_W-1:0] rd_data_q;

  logic [COLOR_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              last_px;
  logic              swap_pt;
  logic              full_now;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_x;

  assign wr_ready = (state_q == FILL);
  assign accept   = wr_valid && wr_ready;
  assign last_px  = (idx_q == IDX_W'(H_ACTIVE - 1));
  assign full_now = (state_q == FULL) ||
                    (accept && last_px);

  // the next line is visible: any line before the last, or the frame wrap
  assign swap_pt = (pixel_x == 16'(LINE_LENGTH - 1)) &&
                   ((line_y < 16'(V_ACTIVE - 1)) ||
                    (line_y == 16'(V_TOTAL - 1)));

  assign rd_en = (pixel_x < 16'(H_ACTIVE)) &&
                 (line_y < 16'(V_ACTIVE)) &&
                 valid_q;

  // bank_q selects the display half; the fill half is the other one
  assign wr_addr = bank_q ? ADDR_W'(idx_q)
                          : ADDR_W'(idx_q) + ADDR_W'(H_ACTIVE);
  assign rd_x    = rd_en ? ADDR_W'(pixel_x) : '0;
  assign rd_addr = bank_q ? rd_x + ADDR_W'(H_ACTIVE) : rd_x;

  // fill FSM, bank swap and underrun bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    und_d   = 1'b0;
    cnt_d   = cnt_q;
    if (accept) begin
      idx_d = idx_q + 1'b1;
      if (last_px) state_d = FULL;
    end
    if (swap_pt) begin
      if (full_now) begin
        bank_d  = ~bank_q;
        valid_d = 1'b1;
        state_d = FILL;
        idx_d   = '0;
      end else begin
        valid_d = 1'b0;
        und_d   = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // control state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= FILL;
      idx_q   <= '0;
      bank_q  <= 1'b0;
      valid_q <= 1'b0;
      und_q   <= 1'b0;
      cnt_q   <= 8'd0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      und_q   <= und_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en;
    end
  end

  // unreset storage so it maps onto block RAM with a registered read
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_addr] <= wr_rgb;
    rd_data_q <= mem_q[rd_addr];
  end

  // the reset enable forces black, also masking any unwritten RAM word
  assign rgb_out        = rd_data_q & {COLOR_W{rd_en_q}};
  assign underrun       = und_q;
  assign underrun_count = cnt_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// tb_vga_line_buffer: directed bench for the ping-pong line buffer,
// with a small producer/display reference model driving expectations.
module tb_vga_line_buffer;

  localparam int HA = 417;
  localparam int LL = 508;
  localparam int VA = 480;
  localparam int VT = 526;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] pixel_x;
  logic [15:0] line_y;
  logic        wr_valid;
  logic [2:0]  wr_rgb;
  logic        wr_ready;
  logic [2:0]  rgb_out;
  logic        underrun;
  logic [7:0]  underrun_count;

  always #5 CLK = ~CLK;

  vga_line_buffer dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .pixel_x        (pixel_x),
    .line_y         (line_y),
    .wr_valid       (wr_valid),
    .wr_rgb         (wr_rgb),
    .wr_ready       (wr_ready),
    .rgb_out        (rgb_out),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // timing counters and model state
  int x = 0;
  int y = 0;
  bit m_full, m_valid, e_und;
  int m_dline, done_line, m_cnt;
  int p_line = 0;
  int p_idx, p_lim, p_xmin, p_pct;
  bit p_on;
  int bad_rgb, bad_rdy, bad_und, bad_cnt, pulses;

  function automatic logic [2:0] pix(input int ln, input int i);
    return 3'((i + 3 * ln) & 7);
  endfunction

  task automatic model_reset();
    m_full  = 0;
    m_valid = 0;
    e_und   = 0;
    m_cnt   = 0;
    p_idx   = 0;
    p_line++;
    p_lim   = HA;
    p_xmin  = 0;
  endtask

  task automatic do_reset();
    RESET_N  = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    model_reset();
    RESET_N = 1'b1;
  endtask

  // one pixel clock: drive, predict, clock, compare, advance counters
  task automatic step();
    bit v, acc, sw;
    logic [2:0] e_rgb;
    pixel_x = 16'(x);
    line_y  = 16'(y);
    v = p_on && (p_idx < p_lim) && (x >= p_xmin) &&
        ($urandom_range(7) < p_pct);
    wr_valid = v;
    wr_rgb   = pix(p_line, p_idx);
    #1;
    if (wr_ready !== !m_full) bad_rdy++;
    acc = v && !m_full;
    e_rgb = (y < VA && x < HA && m_valid) ? pix(m_dline, x) : 3'd0;
    sw = (x == LL - 1) && (y < VA - 1 || y == VT - 1);
    if (acc) begin
      p_idx++;
      if (p_idx == HA) begin
        m_full    = 1;
        done_line = p_line;
        p_line++;
        p_idx = 0;
      end
    end
    e_und = 0;
    if (sw) begin
      if (m_full) begin
        m_full  = 0;
        m_valid = 1;
        m_dline = done_line;
      end else begin
        m_valid = 0;
        e_und   = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge CLK);
    #1;
    if (rgb_out !== e_rgb) bad_rgb++;
    if (underrun !== e_und) bad_und++;
    if (underrun_count !== 8'(m_cnt)) bad_cnt++;
    if (underrun === 1'b1) pulses++;
    x++;
    if (x == LL) begin
      x = 0;
      y = (y == VT - 1) ? 0 : y + 1;
    end
  endtask

  task automatic run_line(input int yy);
    x = 0;
    y = yy;
    repeat (LL) step();
  endtask

  task automatic phase(input string t);
    chk({t, "_rgb"}, bad_rgb, 0);
    chk({t, "_rdy"}, bad_rdy, 0);
    chk({t, "_und"}, bad_und, 0);
    chk({t, "_cnt"}, bad_cnt, 0);
    bad_rgb = 0;
    bad_rdy = 0;
    bad_und = 0;
    bad_cnt = 0;
  endtask

  initial begin
    int nz;
    pixel_x  = '0;
    line_y   = '0;
    wr_valid = 1'b0;
    wr_rgb   = '0;
    p_pct    = 8;
    p_on     = 0;

    // 1: reset values, fill line during frame wrap, show it on line 0
    do_reset();
    chk("rst_rgb", rgb_out, 0);
    chk("rst_und", underrun, 0);
    chk("rst_cnt", underrun_count, 0);
    chk("rst_rdy", wr_ready, 1);
    p_line = 0;
    p_on   = 1;
    x = 0;
    y = VT - 1;
    repeat (HA - 1) step();
    chk("t1_rdy_hi", wr_ready, 1);
    step();
    chk("t1_rdy_lo", wr_ready, 0);
    repeat (LL - HA) step();
    repeat (5) step();
    chk("t1_x4", rgb_out, 4);
    repeat (LL - 5) step();
    run_line(1);
    phase("t1");

    // 2: idle producer for a whole frame
    do_reset();
    p_on   = 0;
    pulses = 0;
    for (int yy = 0; yy < VT; yy++) begin
      y = yy;
      x = 10;
      step();
      y = yy;
      x = LL - 2;
      step();
      y = yy;
      x = LL - 1;
      step();
    end
    chk("t2_pulses", pulses, 480);
    chk("t2_sat", underrun_count, 255);
    phase("t2");

    // 3: producer stalls at 200 pixels across a swap point
    do_reset();
    p_on = 1;
    run_line(VT - 1);
    p_lim  = 200;
    pulses = 0;
    run_line(0);
    chk("t3_und", underrun, 1);
    chk("t3_cnt", underrun_count, 1);
    p_lim = HA;
    x = 0;
    y = 1;
    repeat (HA - 200) step();
    chk("t3_full", wr_ready, 0);
    repeat (LL - (HA - 200)) step();
    chk("t3_pulses", pulses, 1);
    run_line(2);
    phase("t3");

    // 4: last accept lands on the swap cycle
    do_reset();
    p_on   = 1;
    p_xmin = LL - HA;
    run_line(VT - 1);
    chk("t4_und", underrun, 0);
    chk("t4_cnt", underrun_count, 0);
    chk("t4_rdy", wr_ready, 1);
    p_xmin = 0;
    p_on   = 0;
    x = 0;
    y = 0;
    repeat (3) step();
    chk("t4_x2", rgb_out, pix(m_dline, 2));
    repeat (LL - 3) step();
    phase("t4");

    // 5: random producer gaps, including the vertical blank edges
    do_reset();
    p_on  = 1;
    p_pct = 7;
    run_line(VT - 1);
    for (int i = 0; i < 5; i++) run_line(i);
    for (int i = VA - 2; i < VA + 2; i++) run_line(i);
    run_line(VT - 1);
    run_line(0);
    phase("t5");

    // 6: reset pulse in the middle of line 0
    do_reset();
    p_pct = 8;
    run_line(VT - 1);
    x = 0;
    y = 0;
    repeat (101) step();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_rgb_rst", rgb_out, 0);
    model_reset();
    #2;
    RESET_N = 1'b1;
    chk("t6_rdy", wr_ready, 1);
    repeat (LL - 101) step();
    chk("t6_und", underrun, 1);
    nz = 0;
    x = 0;
    y = 1;
    repeat (LL) begin
      step();
      if (rgb_out !== 3'd0) nz++;
    end
    chk("t6_black", nz, 0);
    phase("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
